// File: rtl/direction_light_ctrl.sv
// Per-approach traffic light sequencer: timed GREEN -> YELLOW run on request,
// four-phase done handshake, abort via clear, and flashing-yellow service mode.
module direction_light_ctrl #(
    parameter int DIV_FACTOR = 10,
    parameter int GREEN_SEC  = 5,
    parameter int YELLOW_SEC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic blink,
    output logic light_red,
    output logic light_yellow,
    output logic light_green,
    output logic done,
    output logic busy
);

    localparam int SEC_MAX = (GREEN_SEC > YELLOW_SEC) ? GREEN_SEC : YELLOW_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);
    localparam int DIV_W   = $clog2(DIV_FACTOR);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV_FACTOR - 1);
    localparam logic [SEC_W-1:0] GREEN_LAST  = SEC_W'(GREEN_SEC - 1);
    localparam logic [SEC_W-1:0] YELLOW_LAST = SEC_W'(YELLOW_SEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_DONE,
        S_BLINK
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [SEC_W-1:0]  sec_cnt_reg;
    logic              blink_ph_reg;
    logic              counting;
    logic              tick;

    assign counting = (state_reg == S_GREEN) || (state_reg == S_YELLOW) ||
                      (state_reg == S_BLINK);
    assign tick     = counting && (div_cnt_reg == DIV_LAST);

    // State register plus the tick/second counters, which restart on any state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            div_cnt_reg  <= '0;
            sec_cnt_reg  <= '0;
            blink_ph_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (clear || (state_next != state_reg)) begin
                div_cnt_reg  <= '0;
                sec_cnt_reg  <= '0;
                blink_ph_reg <= 1'b0;
            end else if (counting) begin
                div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
                if (tick && (state_reg == S_BLINK)) begin
                    blink_ph_reg <= ~blink_ph_reg;
                end else if (tick) begin
                    sec_cnt_reg <= sec_cnt_reg + SEC_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (blink) begin
                        state_next = S_BLINK;
                    end else if (enable) begin
                        state_next = S_GREEN;
                    end
                end
                S_GREEN: begin
                    if (tick && (sec_cnt_reg == GREEN_LAST)) begin
                        state_next = S_YELLOW;
                    end
                end
                S_YELLOW: begin
                    if (tick && (sec_cnt_reg == YELLOW_LAST)) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        state_next = S_IDLE;
                    end
                end
                S_BLINK: begin
                    if (!blink) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        light_red    = 1'b0;
        light_yellow = 1'b0;
        light_green  = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        case (state_reg)
            S_IDLE: light_red = 1'b1;
            S_GREEN: begin
                light_green = 1'b1;
                busy        = 1'b1;
            end
            S_YELLOW: begin
                light_yellow = 1'b1;
                busy         = 1'b1;
            end
            S_DONE: begin
                light_red = 1'b1;
                done      = 1'b1;
            end
            S_BLINK: light_yellow = blink_ph_reg;
            default: light_red = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_direction_light_ctrl.sv
// Directed bench: each stimulus cycle queues the hand-computed lamp vector
// {red,yellow,green,done,busy}; a monitor pops and compares at the next falling edge.
module tb_direction_light_ctrl;

    localparam logic [4:0] E_IDLE = 5'b10000;
    localparam logic [4:0] E_GRN  = 5'b00101;
    localparam logic [4:0] E_YEL  = 5'b01001;
    localparam logic [4:0] E_DONE = 5'b10010;
    localparam logic [4:0] E_BOFF = 5'b00000;
    localparam logic [4:0] E_BON  = 5'b01000;

    typedef struct {
        bit         sel;
        logic [4:0] exp;
        string      name;
    } sb_entry_t;

    logic clk;
    logic rst_a, en_a, clr_a, bl_a;
    logic rst_b, en_b, clr_b, bl_b;
    logic red_a, yel_a, grn_a, done_a, busy_a;
    logic red_b, yel_b, grn_b, done_b, busy_b;

    sb_entry_t sb_q[$];
    int checks = 0;
    int errors = 0;

    direction_light_ctrl #(.DIV_FACTOR(4), .GREEN_SEC(3), .YELLOW_SEC(2)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .clear(clr_a), .blink(bl_a),
        .light_red(red_a), .light_yellow(yel_a), .light_green(grn_a),
        .done(done_a), .busy(busy_a)
    );

    direction_light_ctrl #(.DIV_FACTOR(2), .GREEN_SEC(1), .YELLOW_SEC(1)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .clear(clr_b), .blink(bl_b),
        .light_red(red_b), .light_yellow(yel_b), .light_green(grn_b),
        .done(done_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: one expected vector per cycle, compared away from the rising edge.
    initial begin
        sb_entry_t  e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = e.sel ? {red_b, yel_b, grn_b, done_b, busy_b}
                            : {red_a, yel_a, grn_a, done_a, busy_a};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got rygdb=%b expected rygdb=%b at %0t",
                             e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic step(input bit sel, input logic r, input logic en, input logic clr,
                        input logic bl, input logic [4:0] exp, input string name);
        sb_entry_t e;
        if (sel) begin
            rst_b = r; en_b = en; clr_b = clr; bl_b = bl;
        end else begin
            rst_a = r; en_a = en; clr_a = clr; bl_a = bl;
        end
        @(posedge clk);
        #1;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic run(input int n, input bit sel, input logic r, input logic en,
                       input logic clr, input logic bl, input logic [4:0] exp,
                       input string name);
        for (int i = 0; i < n; i++) step(sel, r, en, clr, bl, exp, name);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; bl_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; bl_b = 1'b0;

        // Reset state
        run(2, 0, 1, 1, 0, 0, E_IDLE, "reset_a");
        run(2, 0, 0, 0, 0, 0, E_IDLE, "idle_a");

        // 1: full sequence, done held until enable falls
        run(12, 0, 0, 1, 0, 0, E_GRN,  "t1_green");
        run(8,  0, 0, 1, 0, 0, E_YEL,  "t1_yellow");
        run(10, 0, 0, 1, 0, 0, E_DONE, "t1_done_hold");
        run(2,  0, 0, 0, 0, 0, E_IDLE, "t1_release");

        // 2: clear aborts mid-green, held clear blocks enable, then fresh run
        run(6,  0, 0, 1, 0, 0, E_GRN,  "t2_green_pre");
        run(3,  0, 0, 1, 1, 0, E_IDLE, "t2_clear");
        run(12, 0, 0, 1, 0, 0, E_GRN,  "t2_green_full");
        run(8,  0, 0, 1, 0, 0, E_YEL,  "t2_yellow");
        run(1,  0, 0, 1, 0, 0, E_DONE, "t2_done");
        run(2,  0, 0, 0, 0, 0, E_IDLE, "t2_release");

        // 3: reset mid-yellow, counters restart cleanly
        run(12, 0, 0, 1, 0, 0, E_GRN,  "t3_green");
        run(3,  0, 0, 1, 0, 0, E_YEL,  "t3_yellow_pre");
        run(1,  0, 1, 1, 0, 0, E_IDLE, "t3_reset");
        run(1,  0, 0, 0, 0, 0, E_IDLE, "t3_idle");
        run(12, 0, 0, 1, 0, 0, E_GRN,  "t3_green_fresh");
        run(8,  0, 0, 1, 0, 0, E_YEL,  "t3_yellow_fresh");
        run(1,  0, 0, 1, 0, 0, E_DONE, "t3_done");
        run(2,  0, 0, 0, 0, 0, E_IDLE, "t3_release");

        // 4: enable drops mid-green; sequence completes, done lasts one cycle
        run(5,  0, 0, 1, 0, 0, E_GRN,  "t4_green_en");
        run(7,  0, 0, 0, 0, 0, E_GRN,  "t4_green_noen");
        run(8,  0, 0, 0, 0, 0, E_YEL,  "t4_yellow");
        run(1,  0, 0, 0, 0, 0, E_DONE, "t4_done_pulse");
        run(2,  0, 0, 0, 0, 0, E_IDLE, "t4_idle");

        // 5: blink beats enable, yellow flashes every DIV_FACTOR cycles
        run(4,  0, 0, 1, 0, 1, E_BOFF, "t5_blink_off0");
        run(4,  0, 0, 1, 0, 1, E_BON,  "t5_blink_on0");
        run(4,  0, 0, 1, 0, 1, E_BOFF, "t5_blink_off1");
        run(4,  0, 0, 1, 0, 1, E_BON,  "t5_blink_on1");
        run(1,  0, 0, 1, 0, 0, E_IDLE, "t5_blink_exit");
        run(3,  0, 0, 1, 0, 0, E_GRN,  "t5_green");
        run(4,  0, 0, 1, 0, 1, E_GRN,  "t5_green_blink_ign");
        run(5,  0, 0, 1, 0, 0, E_GRN,  "t5_green_tail");
        run(8,  0, 0, 1, 0, 0, E_YEL,  "t5_yellow");
        run(1,  0, 0, 1, 0, 0, E_DONE, "t5_done");
        run(2,  0, 0, 0, 0, 0, E_IDLE, "t5_release");

        // 6: minimum parameters on the second instance
        run(2, 1, 1, 0, 0, 0, E_IDLE, "t6_reset");
        for (int k = 0; k < 2; k++) begin
            run(2, 1, 0, 1, 0, 0, E_GRN,  "t6_green");
            run(2, 1, 0, 1, 0, 0, E_YEL,  "t6_yellow");
            run(3, 1, 0, 1, 0, 0, E_DONE, "t6_done");
            run(2, 1, 0, 0, 0, 0, E_IDLE, "t6_release");
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
